// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - mm:ss.cc BCD stopwatch with run/stop, clear and lap freeze
// Buttons arrive already synchronized; edges are taken against a one-cycle-delayed copy.
module stopwatch_core #(
  parameter int CLK_DIV = 10000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  output logic [23:0] digits,
  output logic        running,
  output logic        lap_active,
  output logic        update,
  output logic        wrap
);

  localparam logic ST_STOPPED = 1'b0;
  localparam logic ST_RUNNING = 1'b1;

  localparam logic [15:0] PRESC_MAX = 16'(CLK_DIV - 1);
  // Per-digit maximum, also the value that rolls over to zero
  localparam logic [23:0] DIGIT_MAX = 24'h595999;

  logic        ss_dly_q, clr_dly_q, lap_dly_q;
  logic        state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic [23:0] cnt_q, cnt_d;
  logic [23:0] dig_q, dig_d;
  logic        frz_q, frz_d;
  logic        upd_q, upd_d;
  logic        wrap_q, wrap_d;

  logic        ss_edge, clr_edge, clr_act, lap_edge, tick;
  logic [23:0] cnt_inc;

  function automatic logic [23:0] bcd_inc(input logic [23:0] c);
    logic [23:0] r;
    logic        carry;
    r     = c;
    carry = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == DIGIT_MAX[i*4 +: 4]) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // start_stop wins over clear, and an acting clear wins over lap
  assign ss_edge  = start_stop & ~ss_dly_q;
  assign clr_edge = clear & ~clr_dly_q & ~ss_edge;
  assign clr_act  = clr_edge & (state_q == ST_STOPPED);
  assign lap_edge = lap & ~lap_dly_q & ~ss_edge & ~clr_act;

  assign tick    = (state_q == ST_RUNNING) && (presc_q == PRESC_MAX);
  assign cnt_inc = bcd_inc(cnt_q);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    frz_d   = frz_q;
    upd_d   = 1'b0;
    wrap_d  = 1'b0;

    if (ss_edge) begin
      state_d = (state_q == ST_RUNNING) ? ST_STOPPED : ST_RUNNING;
    end

    // The prescaler only moves while running, so a restart resumes a partial tick
    if (state_q == ST_RUNNING) begin
      if (tick) begin
        presc_d = 16'd0;
        cnt_d   = cnt_inc;
        wrap_d  = (cnt_q == DIGIT_MAX);
      end else begin
        presc_d = presc_q + 16'd1;
      end
    end

    if (clr_act) begin
      presc_d = 16'd0;
      cnt_d   = 24'd0;
      dig_d   = 24'd0;
      frz_d   = 1'b0;
      upd_d   = 1'b1;
    end else if (lap_edge && frz_q) begin
      frz_d = 1'b0;
      dig_d = cnt_d;
      upd_d = 1'b1;
    end else if (lap_edge) begin
      frz_d = 1'b1;
    end else if (tick && !frz_q) begin
      dig_d = cnt_d;
      upd_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ss_dly_q  <= 1'b0;
      clr_dly_q <= 1'b0;
      lap_dly_q <= 1'b0;
      state_q   <= ST_STOPPED;
      presc_q   <= 16'd0;
      cnt_q     <= 24'd0;
      dig_q     <= 24'd0;
      frz_q     <= 1'b0;
      upd_q     <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      ss_dly_q  <= start_stop;
      clr_dly_q <= clear;
      lap_dly_q <= lap;
      state_q   <= state_d;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      dig_q     <= dig_d;
      frz_q     <= frz_d;
      upd_q     <= upd_d;
      wrap_q    <= wrap_d;
    end
  end

  assign digits     = dig_q;
  assign running    = (state_q == ST_RUNNING);
  assign lap_active = frz_q;
  assign update     = upd_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// tb/tb_stopwatch_core.sv - directed vector bench for stopwatch_core with CLK_DIV=4
module tb_stopwatch_core;

  logic        clk = 1'b0;
  logic        rst, start_stop, clear, lap;
  logic [23:0] digits;
  logic        running, lap_active, update, wrap;

  int checks = 0;
  int errors = 0;

  stopwatch_core #(.CLK_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_stop(start_stop),
    .clear     (clear),
    .lap       (lap),
    .digits    (digits),
    .running   (running),
    .lap_active(lap_active),
    .update    (update),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ss;
    logic        clr;
    logic        lp;
    int          n;
    logic [23:0] dig;
    logic        run;
    logic        lapa;
    int          upd;
  } vec_t;

  vec_t tbl[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic addv(input logic ss, input logic clr, input logic lp, input int n,
                      input logic [23:0] dig, input logic run, input logic lapa, input int upd);
    vec_t v;
    v.ss = ss; v.clr = clr; v.lp = lp; v.n = n;
    v.dig = dig; v.run = run; v.lapa = lapa; v.upd = upd;
    tbl.push_back(v);
  endtask

  // Restart from reset, run to prescaler 3, then inject a count just before the tick edge
  task automatic preload_tick(input logic [23:0] val, input logic [23:0] exp_dig, input logic exp_wrap);
    rst = 1'b1; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    step();
    rst = 1'b0;
    step();
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
    repeat (3) step();
    force dut.cnt_q = val;
    step();
    release dut.cnt_q;
    chk($sformatf("preload_%06h_digits", val), 32'(digits), 32'(exp_dig));
    chk($sformatf("preload_%06h_update", val), 32'(update), 32'd1);
    chk($sformatf("preload_%06h_wrap", val), 32'(wrap), 32'(exp_wrap));
    chk($sformatf("preload_%06h_running", val), 32'(running), 32'd1);
    step();
    chk($sformatf("preload_%06h_wrap_end", val), 32'(wrap), 32'd0);
    chk($sformatf("preload_%06h_update_end", val), 32'(update), 32'd0);
  endtask

  initial begin
    int upd_cnt;

    //     ss clr lp  n   digits     run lap upd
    addv(1, 0, 0,  1, 24'h000000, 1, 0,  0);
    addv(0, 0, 0, 40, 24'h000010, 1, 0, 10);
    addv(0, 0, 1,  1, 24'h000010, 1, 1,  0);
    addv(0, 0, 0, 20, 24'h000010, 1, 1,  0);
    addv(0, 0, 1,  1, 24'h000015, 1, 0,  1);
    addv(0, 0, 0,  1, 24'h000015, 1, 0,  0);
    addv(1, 0, 0,  1, 24'h000016, 0, 0,  1);
    addv(0, 1, 0,  1, 24'h000000, 0, 0,  1);
    addv(0, 0, 0, 10, 24'h000000, 0, 0,  0);
    addv(1, 0, 0,  1, 24'h000000, 1, 0,  0);
    addv(0, 0, 0,  6, 24'h000001, 1, 0,  1);
    addv(0, 1, 0,  1, 24'h000001, 1, 0,  0);
    addv(0, 0, 0,  1, 24'h000002, 1, 0,  1);
    addv(0, 0, 0,  1, 24'h000002, 1, 0,  0);
    addv(1, 0, 0,  1, 24'h000002, 0, 0,  0);
    addv(0, 0, 0,  5, 24'h000002, 0, 0,  0);
    addv(1, 0, 0,  1, 24'h000002, 1, 0,  0);
    addv(0, 0, 0,  1, 24'h000002, 1, 0,  0);
    addv(0, 0, 0,  1, 24'h000003, 1, 0,  1);
    addv(0, 0, 0, 16, 24'h000007, 1, 0,  4);
    addv(1, 0, 0,  1, 24'h000007, 0, 0,  0);
    addv(0, 0, 0,  2, 24'h000007, 0, 0,  0);
    addv(1, 1, 0,  1, 24'h000007, 1, 0,  0);
    addv(0, 0, 0,  1, 24'h000007, 1, 0,  0);
    addv(1, 0, 0,  1, 24'h000007, 0, 0,  0);
    addv(0, 0, 1,  1, 24'h000007, 0, 1,  0);
    addv(0, 0, 0,  3, 24'h000007, 0, 1,  0);
    addv(0, 0, 1,  1, 24'h000007, 0, 0,  1);
    addv(0, 0, 0,  2, 24'h000007, 0, 0,  0);
    addv(0, 0, 1,  1, 24'h000007, 0, 1,  0);
    addv(0, 0, 0,  1, 24'h000007, 0, 1,  0);
    addv(0, 1, 0,  1, 24'h000000, 0, 0,  1);
    addv(0, 0, 0,  1, 24'h000000, 0, 0,  0);
    addv(1, 0, 0,  1, 24'h000000, 1, 0,  0);
    addv(0, 0, 0,  3, 24'h000000, 1, 0,  0);
    addv(0, 0, 0,  1, 24'h000001, 1, 0,  1);

    rst = 1'b1; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    repeat (3) step();
    chk("reset_digits", 32'(digits), 32'h0);
    chk("reset_running", 32'(running), 32'd0);
    chk("reset_lap_active", 32'(lap_active), 32'd0);
    chk("reset_update", 32'(update), 32'd0);
    chk("reset_wrap", 32'(wrap), 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < tbl.size(); i++) begin
      start_stop = tbl[i].ss;
      clear      = tbl[i].clr;
      lap        = tbl[i].lp;
      upd_cnt    = 0;
      repeat (tbl[i].n) begin
        step();
        if (update) upd_cnt++;
      end
      chk($sformatf("vec%0d_digits", i), 32'(digits), 32'(tbl[i].dig));
      chk($sformatf("vec%0d_running", i), 32'(running), 32'(tbl[i].run));
      chk($sformatf("vec%0d_lap_active", i), 32'(lap_active), 32'(tbl[i].lapa));
      chk($sformatf("vec%0d_update_count", i), 32'(upd_cnt), 32'(tbl[i].upd));
    end

    preload_tick(24'h595999, 24'h000000, 1'b1);
    preload_tick(24'h005999, 24'h010000, 1'b0);
    preload_tick(24'h095999, 24'h100000, 1'b0);
    preload_tick(24'h000999, 24'h001000, 1'b0);

    // Reset mid-run with a lap freeze, holding start_stop high across release
    rst = 1'b1; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    step();
    rst = 1'b0;
    step();
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
    repeat (5) step();
    lap = 1'b1;
    step();
    lap = 1'b0;
    step();
    chk("midrun_lap_active", 32'(lap_active), 32'd1);
    chk("midrun_digits", 32'(digits), 32'h000001);
    rst = 1'b1; start_stop = 1'b1;
    step();
    chk("midrst_running", 32'(running), 32'd0);
    chk("midrst_lap_active", 32'(lap_active), 32'd0);
    chk("midrst_digits", 32'(digits), 32'h0);
    chk("midrst_update", 32'(update), 32'd0);
    chk("midrst_wrap", 32'(wrap), 32'd0);
    repeat (6) step();
    chk("midrst_hold_running", 32'(running), 32'd0);
    chk("midrst_hold_update", 32'(update), 32'd0);
    rst = 1'b0;
    step();
    chk("release_held_running", 32'(running), 32'd1);
    repeat (3) step();
    chk("release_held_still_running", 32'(running), 32'd1);
    start_stop = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
